ddr_line_fetcher: RTL

- Responder to the fill-FIFO sequencer: on each go_fill_fifo pulse with ddr_addr_to_read, fetches one half-FIFO worth of pixel words from DDR and pushes them into the HDMI pixel FIFO.
- Splits each fill into fixed-length bursts on a simple request/ack read master port.
- Throttles on FIFO free space and signals completion back to the sequencer.

---
 rtl/ddr_line_fetcher.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ddr_line_fetcher.sv
// Fetches NUM_BURSTS bursts of BURST_WORDS words from DDR per fill request and streams them into the pixel FIFO.
// Optional read watchdog enabled by defining RD_TIMEOUT_EN.
module ddr_line_fetcher #(
    parameter int BURST_WORDS    = 16,
    parameter int NUM_BURSTS     = 4,
    parameter int FIFO_CNT_W     = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go_fill_fifo,
    input  logic [31:0]           ddr_addr_to_read,
    output logic                  busy,
    output logic                  fill_done,
    output logic                  go_dropped,
    output logic                  rd_req,
    output logic [31:0]           rd_addr,
    output logic [7:0]            rd_len,
    input  logic                  rd_ack,
    input  logic [31:0]           rd_data,
    input  logic                  rd_data_valid,
    input  logic [FIFO_CNT_W-1:0] fifo_free,
    output logic                  fifo_wr_en,
    output logic [31:0]           fifo_wr_data,
    output logic                  rd_error
);

    localparam int          BEAT_W      = $clog2(BURST_WORDS);
    localparam int          BCNT_W      = $clog2(NUM_BURSTS + 1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS * 4);

    typedef enum logic [1:0] {IDLE, SPACE, REQ, DATA} state_t;

    state_t              state_reg;
    logic [31:0]         cur_addr_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic [BCNT_W-1:0]   burst_cnt_reg;
    logic                busy_reg;
    logic                fill_done_reg;
    logic                go_dropped_reg;
    logic                rd_req_reg;
    logic [31:0]         rd_addr_reg;
    logic                fifo_wr_en_reg;
    logic [31:0]         fifo_wr_data_reg;

    logic space_ok;
    logic last_beat;
    logic last_burst;
    logic timeout_hit;

    // A write issued this cycle has not yet been reflected in fifo_free.
    assign space_ok   = 32'(fifo_free) >= (32'(BURST_WORDS) + {31'b0, fifo_wr_en_reg});
    assign last_beat  = (beat_cnt_reg == BEAT_W'(BURST_WORDS - 1));
    assign last_burst = (burst_cnt_reg == BCNT_W'(NUM_BURSTS - 1));

`ifdef RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            rd_error_reg;
    logic            in_xfer;

    assign in_xfer     = (state_reg == REQ) || (state_reg == DATA);
    assign timeout_hit = in_xfer && !rd_ack && !rd_data_valid
                         && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_reg   <= '0;
            rd_error_reg <= 1'b0;
        end else begin
            if (!in_xfer || rd_ack || rd_data_valid || timeout_hit)
                to_cnt_reg <= '0;
            else
                to_cnt_reg <= to_cnt_reg + 1'b1;
            if (timeout_hit)
                rd_error_reg <= 1'b1;
        end
    end

    assign rd_error = rd_error_reg;
`else
    assign timeout_hit = 1'b0;
    assign rd_error    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            cur_addr_reg     <= '0;
            beat_cnt_reg     <= '0;
            burst_cnt_reg    <= '0;
            busy_reg         <= 1'b0;
            fill_done_reg    <= 1'b0;
            go_dropped_reg   <= 1'b0;
            rd_req_reg       <= 1'b0;
            rd_addr_reg      <= '0;
            fifo_wr_en_reg   <= 1'b0;
            fifo_wr_data_reg <= '0;
        end else begin
            fill_done_reg  <= 1'b0;
            fifo_wr_en_reg <= 1'b0;

            if (go_fill_fifo && state_reg != IDLE)
                go_dropped_reg <= 1'b1;

            if (timeout_hit) begin
                rd_req_reg    <= 1'b0;
                fill_done_reg <= 1'b1;
                busy_reg      <= 1'b0;
                state_reg     <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (go_fill_fifo) begin
                            cur_addr_reg  <= ddr_addr_to_read;
                            burst_cnt_reg <= '0;
                            busy_reg      <= 1'b1;
                            state_reg     <= SPACE;
                        end
                    end
                    SPACE: begin
                        if (space_ok) begin
                            rd_req_reg  <= 1'b1;
                            rd_addr_reg <= cur_addr_reg;
                            state_reg   <= REQ;
                        end
                    end
                    REQ: begin
                        if (rd_ack) begin
                            rd_req_reg   <= 1'b0;
                            beat_cnt_reg <= '0;
                            state_reg    <= DATA;
                        end
                    end
                    DATA: begin
                        if (rd_data_valid) begin
                            fifo_wr_en_reg   <= 1'b1;
                            fifo_wr_data_reg <= rd_data;
                            beat_cnt_reg     <= beat_cnt_reg + 1'b1;
                            if (last_beat) begin
                                cur_addr_reg  <= cur_addr_reg + BURST_BYTES;
                                burst_cnt_reg <= burst_cnt_reg + 1'b1;
                                if (last_burst) begin
                                    fill_done_reg <= 1'b1;
                                    busy_reg      <= 1'b0;
                                    state_reg     <= IDLE;
                                end else begin
                                    state_reg <= SPACE;
                                end
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign busy         = busy_reg;
    assign fill_done    = fill_done_reg;
    assign go_dropped   = go_dropped_reg;
    assign rd_req       = rd_req_reg;
    assign rd_addr      = rd_addr_reg;
    assign rd_len       = 8'(BURST_WORDS);
    assign fifo_wr_en   = fifo_wr_en_reg;
    assign fifo_wr_data = fifo_wr_data_reg;

endmodule
